id_ex_stage: RTL

- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
- Captures decoded operands and control from ID each cycle and presents them to EX.
- Its ID_EX_RegRs/ID_EX_RegRt/ID_EX_RegRd outputs feed the forwarding unit directly.
- Detects load-use hazards, stalls PC and IF/ID, inserts bubbles, honours branch flushes, and keeps saturating stall/flush counters for performance debug.

---
 rtl/id_ex_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush handling and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegRt,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegRd,
  input  logic [DATA_W-1:0]     IF_ID_PC4,
  input  logic [DATA_W-1:0]     ReadData1,
  input  logic [DATA_W-1:0]     ReadData2,
  input  logic [DATA_W-1:0]     SignExtImm,
  input  logic                  Ctrl_RegWrite,
  input  logic                  Ctrl_MemtoReg,
  input  logic                  Ctrl_MemRead,
  input  logic                  Ctrl_MemWrite,
  input  logic                  Ctrl_Branch,
  input  logic                  Ctrl_ALUSrc,
  input  logic                  Ctrl_RegDst,
  input  logic [1:0]            Ctrl_ALUOp,
  input  logic                  Flush,
  output logic [REG_ADDR_W-1:0] ID_EX_RegRs,
  output logic [REG_ADDR_W-1:0] ID_EX_RegRt,
  output logic [REG_ADDR_W-1:0] ID_EX_RegRd,
  output logic [DATA_W-1:0]     ID_EX_PC4,
  output logic [DATA_W-1:0]     ID_EX_ReadData1,
  output logic [DATA_W-1:0]     ID_EX_ReadData2,
  output logic [DATA_W-1:0]     ID_EX_SignExtImm,
  output logic                  ID_EX_RegWrite,
  output logic                  ID_EX_MemtoReg,
  output logic                  ID_EX_MemRead,
  output logic                  ID_EX_MemWrite,
  output logic                  ID_EX_Branch,
  output logic                  ID_EX_ALUSrc,
  output logic                  ID_EX_RegDst,
  output logic [1:0]            ID_EX_ALUOp,
  output logic                  ID_EX_Valid,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  Stall,
  output logic [CNT_W-1:0]      Stall_Count,
  output logic [CNT_W-1:0]      Flush_Count
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     pc4;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;
    logic [DATA_W-1:0]     imm;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  alu_src;
    logic                  reg_dst;
    logic [1:0]            alu_op;
    logic                  valid;
  } id_ex_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  id_ex_t            id_in;
  id_ex_t            ex_q, ex_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              hazard;
  logic              stall;

  always_comb begin
    id_in            = '0;
    id_in.rs         = IF_ID_RegRs;
    id_in.rt         = IF_ID_RegRt;
    id_in.rd         = IF_ID_RegRd;
    id_in.pc4        = IF_ID_PC4;
    id_in.rdata1     = ReadData1;
    id_in.rdata2     = ReadData2;
    id_in.imm        = SignExtImm;
    id_in.reg_write  = Ctrl_RegWrite;
    id_in.mem_to_reg = Ctrl_MemtoReg;
    id_in.mem_read   = Ctrl_MemRead;
    id_in.mem_write  = Ctrl_MemWrite;
    id_in.branch     = Ctrl_Branch;
    id_in.alu_src    = Ctrl_ALUSrc;
    id_in.reg_dst    = Ctrl_RegDst;
    id_in.alu_op     = Ctrl_ALUOp;
    id_in.valid      = 1'b1;
  end

  // A load writing $0 never produces a usable value, so it cannot cause a stall.
  always_comb begin
    hazard = ex_q.mem_read && ex_q.valid && (ex_q.rt != '0) &&
             ((ex_q.rt == IF_ID_RegRs) || (ex_q.rt == IF_ID_RegRt));
    stall  = hazard && !Flush;
  end

  always_comb begin
    ex_d        = id_in;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Flush) begin
      ex_d = '0;
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else if (stall) begin
      ex_d = '0;
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ID_EX_RegRs      = ex_q.rs;
  assign ID_EX_RegRt      = ex_q.rt;
  assign ID_EX_RegRd      = ex_q.rd;
  assign ID_EX_PC4        = ex_q.pc4;
  assign ID_EX_ReadData1  = ex_q.rdata1;
  assign ID_EX_ReadData2  = ex_q.rdata2;
  assign ID_EX_SignExtImm = ex_q.imm;
  assign ID_EX_RegWrite   = ex_q.reg_write;
  assign ID_EX_MemtoReg   = ex_q.mem_to_reg;
  assign ID_EX_MemRead    = ex_q.mem_read;
  assign ID_EX_MemWrite   = ex_q.mem_write;
  assign ID_EX_Branch     = ex_q.branch;
  assign ID_EX_ALUSrc     = ex_q.alu_src;
  assign ID_EX_RegDst     = ex_q.reg_dst;
  assign ID_EX_ALUOp      = ex_q.alu_op;
  assign ID_EX_Valid      = ex_q.valid;
  assign Stall            = stall;
  assign PC_Write         = !stall;
  assign IF_ID_Write      = !stall;
  assign Stall_Count      = stall_cnt_q;
  assign Flush_Count      = flush_cnt_q;

endmodule
